lsu_mem_initiator: RTL and testbench

- Load/store initiator between the core's execute stage and the byte-lane data memory. The data memory has synchronous RAM lanes and 10-bit byte addressing.
- Accepts one RISC-V load/store request per transaction over a valid/ready handshake.
- Decodes funct3 into the memory width/sign encoding and sequences the memory's one-cycle read latency.
- Holds the address and width stable while the memory output steering mux settles, then returns the load data or a store acknowledge.

---
 rtl/lsu_mem_initiator_if.sv | 69 ++++++
 rtl/lsu_mem_initiator.sv | 173 +++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for lsu_mem_initiator.
//
// lsu_req_if : core-side request/response channel.
//   master = execute stage, slave = load/store initiator.
//   req_valid/req_ready  request handshake
//   req_store            1 = store, 0 = load
//   req_funct3           RISC-V funct3 of the access
//   req_addr             byte address
//   req_wdata            store data, right-aligned
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load result (0 for stores and faults)
//   rsp_err              access fault, no write performed
//
// lsu_mem_if : byte-lane data memory port.
//   master = load/store initiator, slave = data memory.
//   mem_addr   byte address
//   mem_wdata  write data, right-aligned
//   mem_wren   write enable
//   mem_width  00 byte, 01 half, 11 word
//   mem_sign   sign-extend loads
//   mem_rdata  read data, valid the cycle after the address is presented
// ----------------------------------------------------------------------------
interface lsu_req_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [1:0]        mem_width;
    logic              mem_sign;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_wren, mem_width, mem_sign,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wren, mem_width, mem_sign,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// ----------------------------------------------------------------------------
// lsu_mem_initiator
//
// Load/store initiator between the execute stage and a byte-lane data memory
// with synchronous RAM lanes. One request is handled at a time:
//   IDLE -> ACCESS -> READ -> DONE   (legal load)
//   IDLE -> ACCESS -> DONE           (legal store, one-cycle write pulse)
//   IDLE -> DONE                     (illegal request, rsp_err=1)
// Address, width and sign are held across ACCESS and READ so the memory's
// output steering mux stays settled while its read data is captured.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   req    lsu_req_if.slave  - request/response channel from the core
//   mem    lsu_mem_if.master - data memory port
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned half or word access is
//                         faulted in IDLE (no memory cycle). When undefined,
//                         misaligned accesses are passed to the memory, which
//                         performs the lane rotation.
// ----------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_READ,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_store;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wren;
    logic [1:0]        r_mem_width;
    logic              r_mem_sign;

    logic [1:0]        w_width;
    logic              w_sign;
    logic              w_illegal;

    // funct3 decode into memory width/sign plus legality of the request.
    always_comb begin
        w_width   = 2'b11;
        w_sign    = 1'b0;
        w_illegal = 1'b0;
        if (req.req_store) begin
            case (req.req_funct3)
                3'b000:  w_width = 2'b00;
                3'b001:  w_width = 2'b01;
                3'b010:  w_width = 2'b11;
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (req.req_funct3)
                3'b000:  begin w_width = 2'b00; w_sign = 1'b1; end
                3'b001:  begin w_width = 2'b01; w_sign = 1'b1; end
                3'b010:  begin w_width = 2'b11; w_sign = 1'b0; end
                3'b100:  begin w_width = 2'b00; w_sign = 1'b0; end
                3'b101:  begin w_width = 2'b01; w_sign = 1'b0; end
                default: w_illegal = 1'b1;
            endcase
        end
        // Anything beyond the memory's byte address range faults.
        if (|req.req_addr[31:ADDR_W]) begin
            w_illegal = 1'b1;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((w_width == 2'b01 && req.req_addr[0]) ||
            (w_width == 2'b11 && req.req_addr[1:0] != 2'b00)) begin
            w_illegal = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_mem_width <= 2'b11;
            r_mem_sign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_store     <= req.req_store;
                        if (w_illegal) begin
                            // Fault without touching the memory port.
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mem_addr  <= req.req_addr[ADDR_W-1:0];
                            r_mem_width <= w_width;
                            r_mem_sign  <= w_sign;
                            r_mem_wdata <= req.req_wdata;
                            r_mem_wren  <= req.req_store;
                            r_state     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // Write pulse lasts only this cycle; address stays put.
                    r_mem_wren <= 1'b0;
                    if (r_store) begin
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // RAM output is valid now; extension is done by the
                    // memory steering mux using the held width/sign.
                    r_rsp_rdata <= mem.mem_rdata;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (req.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mem_wren  <= 1'b0;
                end
            endcase
        end
    end

    assign req.req_ready = r_req_ready;
    assign req.rsp_valid = r_rsp_valid;
    assign req.rsp_err   = r_rsp_err;
    assign req.rsp_rdata = r_rsp_rdata;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_wren  = r_mem_wren;
    assign mem.mem_width = r_mem_width;
    assign mem.mem_sign  = r_mem_sign;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    lsu_req_if #(.DATA_W(32))              rq ();
    lsu_mem_if #(.ADDR_W(10), .DATA_W(32)) mm ();

    lsu_mem_initiator #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rq),
        .mem   (mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: synchronous read, lane rotation with row wrap.
    logic [7:0]  dmem [0:1023];
    logic [31:0] r_mdata;
    logic [9:0]  ma0, ma1, ma2, ma3;
    assign ma0 = mm.mem_addr;
    assign ma1 = mm.mem_addr + 10'd1;
    assign ma2 = mm.mem_addr + 10'd2;
    assign ma3 = mm.mem_addr + 10'd3;
    assign mm.mem_rdata = r_mdata;

    always @(posedge clk) begin
        case (mm.mem_width)
            2'b00:   r_mdata <= {{24{mm.mem_sign & dmem[ma0][7]}}, dmem[ma0]};
            2'b01:   r_mdata <= {{16{mm.mem_sign & dmem[ma1][7]}}, dmem[ma1], dmem[ma0]};
            default: r_mdata <= {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma0]};
        endcase
        if (mm.mem_wren) begin
            dmem[ma0] = mm.mem_wdata[7:0];
            if (mm.mem_width != 2'b00) dmem[ma1] = mm.mem_wdata[15:8];
            if (mm.mem_width == 2'b11) begin
                dmem[ma2] = mm.mem_wdata[23:16];
                dmem[ma3] = mm.mem_wdata[31:24];
            end
        end
    end

    // Reference model: flat byte array plus RISC-V load/store rules.
    logic [7:0] ref_mem [0:1023];

    function automatic int ref_size(input logic st, input logic [2:0] f3);
        if (st) begin
            case (f3)
                3'd0: return 1;
                3'd1: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end
    endfunction

    function automatic logic ref_illegal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        nb = ref_size(st, f3);
        if (nb == 0 || a > 32'h3FF) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % 32'(nb)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        logic [9:0]  ia;
        int          nb;
        nb = ref_size(1'b0, f3);
        v  = '0;
        for (int i = 0; i < nb; i++) begin
            ia = a[9:0] + 10'(i);
            v[8*i +: 8] = ref_mem[ia];
        end
        if (f3 == 3'd0 && v[7])  v[31:8]  = '1;
        if (f3 == 3'd1 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [9:0] ia;
        for (int i = 0; i < ref_size(1'b1, f3); i++) begin
            ia = a[9:0] + 10'(i);
            ref_mem[ia] = wd[8*i +: 8];
        end
    endtask

    // One request from IDLE; returns once rsp_valid is seen (DUT left in DONE).
    // lat = k means rsp_valid was first seen high at edge N+k, N = accept edge.
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int wc, output logic [9:0] wa,
                       output logic [1:0] ww, output logic [31:0] wdat,
                       output logic [9:0] a1, output logic [9:0] a2);
        rq.req_store  = st;
        rq.req_funct3 = f3;
        rq.req_addr   = a;
        rq.req_wdata  = wd;
        rq.req_valid  = 1'b1;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        lat = 0; wc = 0; rd = '0; er = 1'b0; wa = '0; ww = '0; wdat = '0; a1 = '0; a2 = '0;
        for (int k = 1; k <= 16 && lat == 0; k++) begin
            @(negedge clk);
            if (mm.mem_wren) begin
                wc++;
                wa = mm.mem_addr; ww = mm.mem_width; wdat = mm.mem_wdata;
            end
            if (k == 1) a1 = mm.mem_addr;
            if (k == 2) a2 = mm.mem_addr;
            if (rq.rsp_valid) begin
                lat = k; rd = rq.rsp_rdata; er = rq.rsp_err;
            end
        end
    endtask

    task automatic ack(input int hold);
        repeat (hold) @(negedge clk);
        rq.rsp_ready = 1'b1;
        @(posedge clk);
        #1 rq.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (rq.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", rq.req_ready); end
        n_tests++; if (rq.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rq.rsp_valid); end
        n_tests++; if (rq.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rq.rsp_err); end
        n_tests++; if (rq.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=0", rq.rsp_rdata); end
        n_tests++; if (mm.mem_addr !== 10'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mm.mem_addr); end
        n_tests++; if (mm.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=0", mm.mem_wdata); end
        n_tests++; if (mm.mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wren got=%b exp=0", mm.mem_wren); end
        n_tests++; if (mm.mem_width !== 2'b11) begin n_fail++; $display("FAIL reset_mem_width got=%b exp=11", mm.mem_width); end
        n_tests++; if (mm.mem_sign !== 1'b0) begin n_fail++; $display("FAIL reset_mem_sign got=%b exp=0", mm.mem_sign); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load_word();
        logic [31:0] rd, wdat; logic er; int lat, wc; logic [9:0] wa, a1, a2; logic [1:0] ww;
        txn(1'b1, 3'b010, 32'h010, 32'h8899AABB, rd, er, lat, wc, wa, ww, wdat, a1, a2);
        ref_store(3'b010, 32'h010, 32'h8899AABB);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err got=%b exp=0", er); end
        n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL sw_wren_cycles got=%0d exp=1", wc); end
        n_tests++; if (wa !== 10'h010 || ww !== 2'b11 || wdat !== 32'h8899AABB) begin
            n_fail++; $display("FAIL sw_mem_bus got addr=%h width=%b wdata=%h exp 010/11/8899aabb", wa, ww, wdat); end
        ack(0);
        n_tests++; if (rq.rsp_valid !== 1'b0 || rq.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL sw_after_ack got valid=%b ready=%b exp 0/1", rq.rsp_valid, rq.req_ready); end
        txn(1'b0, 3'b010, 32'h010, 32'h0, rd, er, lat, wc, wa, ww, wdat, a1, a2);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        n_tests++; if (rd !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_rdata got=%h exp=8899aabb", rd); end
        n_tests++; if (wc !== 0) begin n_fail++; $display("FAIL lw_wren got=%0d exp=0", wc); end
        ack(0);
    endtask

    task automatic test_byte_sign();
        logic [31:0] rd, wdat; logic er; int lat, wc; logic [9:0] wa, a1, a2; logic [1:0] ww;
        txn(1'b1, 3'b000, 32'h025, 32'h12345680, rd, er, lat, wc, wa, ww, wdat, a1, a2);
        ref_store(3'b000, 32'h025, 32'h12345680);
        n_tests++; if (wc !== 1 || ww !== 2'b00) begin n_fail++; $display("FAIL sb_write got cycles=%0d width=%b exp 1/00", wc, ww); end
        ack(1);
        txn(1'b0, 3'b000, 32'h025, 32'h0, rd, er, lat, wc, wa, ww, wdat, a1, a2);
        n_tests++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got=%h exp=ffffff80", rd); end
        n_tests++; if (a1 !== 10'h025 || a2 !== 10'h025) begin n_fail++; $display("FAIL lb_addr_hold got=%h,%h exp=025", a1, a2); end
        ack(0);
        txn(1'b0, 3'b100, 32'h025, 32'h0, rd, er, lat, wc, wa, ww, wdat, a1, a2);
        n_tests++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata got=%h exp=00000080", rd); end
        n_tests++; if (a1 !== 10'h025 || a2 !== 10'h025) begin n_fail++; $display("FAIL lbu_addr_hold got=%h,%h exp=025", a1, a2); end
        ack(2);
    endtask

    task automatic test_misalign();
        logic [31:0] rd, wdat; logic er; int lat, wc; logic [9:0] wa, a1, a2; logic [1:0] ww;
        dmem[3] = 8'h0D; ref_mem[3] = 8'h0D;
        dmem[4] = 8'hF0; ref_mem[4] = 8'hF0;
        txn(1'b0, 3'b001, 32'h003, 32'h0, rd, er, lat, wc, wa, ww, wdat, a1, a2);
`ifdef LSU_MISALIGN_TRAP_EN
        n_tests++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL lh_misalign got err=%b lat=%0d rdata=%h exp 1/1/0", er, lat, rd); end
`else
        n_tests++; if (er !== 1'b0 || lat !== 3 || rd !== 32'hFFFFF00D) begin
            n_fail++; $display("FAIL lh_misalign got err=%b lat=%0d rdata=%h exp 0/3/fffff00d", er, lat, rd); end
`endif
        n_tests++; if (wc !== 0) begin n_fail++; $display("FAIL lh_misalign_wren got=%0d exp=0", wc); end
        ack(0);
    endtask

    task automatic test_illegal();
        logic [31:0] rd, wdat; logic er; int lat, wc; logic [9:0] wa, a1, a2; logic [1:0] ww;
        logic        cst [7];
        logic [2:0]  cf3 [7];
        logic [31:0] cad [7];
        cst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cf3 = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b111, 3'b010, 3'b000};
        cad = '{32'h004, 32'h008, 32'h00C, 32'h020, 32'h024, 32'h00000400, 32'h80000001};
        for (int i = 0; i < 7; i++) begin
            txn(cst[i], cf3[i], cad[i], 32'hDEADBEEF, rd, er, lat, wc, wa, ww, wdat, a1, a2);
            n_tests++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wc !== 0) begin
                n_fail++; $display("FAIL illegal_%0d got err=%b rdata=%h lat=%0d wren=%0d exp 1/0/1/0", i, er, rd, lat, wc); end
            ack(i % 2);
            n_tests++; if (rq.rsp_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear_%0d got=%b exp=0", i, rq.rsp_err); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd, wdat; logic er; int lat, wc; logic [9:0] wa, a1, a2; logic [1:0] ww;
        txn(1'b0, 3'b010, 32'h010, 32'h0, rd, er, lat, wc, wa, ww, wdat, a1, a2);
        rq.req_store = 1'b1; rq.req_funct3 = 3'b010; rq.req_addr = 32'h200; rq.req_wdata = 32'h0BADF00D;
        rq.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (rq.rsp_valid !== 1'b1 || rq.rsp_rdata !== rd || rq.req_ready !== 1'b0 || mm.mem_wren !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d got valid=%b rdata=%h ready=%b wren=%b exp 1/%h/0/0",
                                   c, rq.rsp_valid, rq.rsp_rdata, rq.req_ready, mm.mem_wren, rd); end
        end
        rq.req_valid = 1'b0;
        n_tests++; if (rd !== 32'h8899AABB) begin n_fail++; $display("FAIL hold_rdata got=%h exp=8899aabb", rd); end
        ack(0);
        n_tests++; if (rq.rsp_valid !== 1'b0 || rq.rsp_rdata !== 32'h0 || rq.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release got valid=%b rdata=%h ready=%b exp 0/0/1", rq.rsp_valid, rq.rsp_rdata, rq.req_ready); end
        n_tests++; if (dmem[10'h200] !== ref_mem[10'h200]) begin
            n_fail++; $display("FAIL hold_no_write got=%h exp=%h", dmem[10'h200], ref_mem[10'h200]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] old0;
        int         bad;
        old0 = dmem[10'h100];
        rq.req_store = 1'b1; rq.req_funct3 = 3'b010; rq.req_addr = 32'h100; rq.req_wdata = 32'hCAFEBABE;
        rq.req_valid = 1'b1;
        @(posedge clk);
        #2;
        n_tests++; if (mm.mem_wren !== 1'b1) begin n_fail++; $display("FAIL rstmid_wren_before got=%b exp=1", mm.mem_wren); end
        rst_n = 1'b0;
        rq.req_valid = 1'b0;
        #1;
        n_tests++; if (mm.mem_wren !== 1'b0 || rq.rsp_valid !== 1'b0 || rq.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_async got wren=%b valid=%b ready=%b exp 0/0/1", mm.mem_wren, rq.rsp_valid, rq.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rq.rsp_valid !== 1'b0 || mm.mem_wren !== 1'b0) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_no_rsp got=%0d bad cycles exp=0", bad); end
        n_tests++; if (dmem[10'h100] !== old0) begin n_fail++; $display("FAIL rstmid_no_write got=%h exp=%h", dmem[10'h100], old0); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wdat, a, wd, exp_rd; logic er; int lat, wc; logic [9:0] wa, a1, a2; logic [1:0] ww;
        logic st, ill; logic [2:0] f3; int r, exp_lat, exp_wc;
        for (int t = 0; t < 48; t++) begin
            st = 1'($urandom_range(1, 0));
            r  = int'($urandom_range(9, 0));
            if (r == 0) f3 = 3'($urandom_range(7, 0));
            else if (st) f3 = 3'($urandom_range(2, 0));
            else begin
                r = int'($urandom_range(4, 0));
                f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
            end
            r = int'($urandom_range(9, 0));
            if (t < 2) a = 32'h3FF;
            else if (r == 0) a = $urandom | 32'h400;
            else a = {22'd0, 10'($urandom_range(1023, 0))};
            if (t == 0) begin st = 1'b1; f3 = 3'b010; end
            if (t == 1) begin st = 1'b0; f3 = 3'b010; end
            wd = $urandom;
            ill     = ref_illegal(st, f3, a);
            exp_lat = ill ? 1 : (st ? 2 : 3);
            exp_wc  = (!ill && st) ? 1 : 0;
            exp_rd  = (ill || st) ? 32'h0 : ref_load(f3, a);
            txn(st, f3, a, wd, rd, er, lat, wc, wa, ww, wdat, a1, a2);
            if (!ill && st) ref_store(f3, a, wd);
            n_tests++; if (er !== ill || lat !== exp_lat || wc !== exp_wc || rd !== exp_rd) begin
                n_fail++; $display("FAIL rand_%0d st=%b f3=%0d addr=%h got err=%b lat=%0d wren=%0d rdata=%h exp %b/%0d/%0d/%h",
                                   t, st, f3, a, er, lat, wc, rd, ill, exp_lat, exp_wc, exp_rd); end
            ack(int'($urandom_range(2, 0)));
        end
    endtask

    initial begin
        logic [7:0] b;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        rq.req_valid = 1'b0; rq.req_store = 1'b0; rq.req_funct3 = 3'b0;
        rq.req_addr  = 32'h0; rq.req_wdata = 32'h0; rq.rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            dmem[i] = b;
            ref_mem[i] = b;
        end
        @(negedge clk);
        test_reset();
        test_store_load_word();
        test_byte_sign();
        test_misalign();
        test_illegal();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
